// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the data-side memory system.
//   - address region codes (addr[31:28])
//   - peripheral register word offsets (addr[7:2])
//   - STATUS register bit positions
package mmio_pkg;

    localparam logic [3:0] REGION_RAM    = 4'h0;
    localparam logic [3:0] REGION_PERIPH = 4'h1;

    localparam logic [5:0] GPIO_OUT  = 6'h00;
    localparam logic [5:0] GPIO_IN   = 6'h01;
    localparam logic [5:0] TIMER_CNT = 6'h02;
    localparam logic [5:0] TIMER_CMP = 6'h03;
    localparam logic [5:0] STATUS    = 6'h04;

    localparam int MATCH_BIT = 0;
    localparam int EN_BIT    = 1;

    // Peripheral word offset of a byte address.
    function automatic logic [5:0] word_off(input logic [31:0] a);
        return a[7:2];
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: 32-bit timer with compare and a sticky match flag.
// Ports:
//   clk_i, rst_i      clock, async active-low reset
//   cnt_we_i          load CNT from wdata_i (overrides increment/reload)
//   cmp_we_i          load CMP from wdata_i
//   status_we_i       STATUS write: bit MATCH is W1C, bit EN is R/W
//   wdata_i           CPU write data
//   cnt_o, cmp_o      current CNT / CMP
//   match_o, en_o     current MATCH / EN
//   irq_o             level interrupt, equal to MATCH
module mmio_timer
    import mmio_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cnt_we_i,
    input  logic         cmp_we_i,
    input  logic         status_we_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cmp_o,
    output logic         match_o,
    output logic         en_o,
    output logic         irq_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] cmp_q, cmp_d;
    logic         match_q, match_d;
    logic         en_q, en_d;
    logic         hit;

    // Match is judged on the pre-edge EN, so a STATUS write enabling the
    // timer only counts from the following cycle.
    assign hit = en_q && (cnt_q == cmp_q);

    always_comb begin
        cnt_d   = cnt_q;
        cmp_d   = cmp_q;
        match_d = match_q;
        en_d    = en_q;

        if (cnt_we_i)  cnt_d = wdata_i;
        else if (hit)  cnt_d = '0;
        else if (en_q) cnt_d = cnt_q + 1'b1;

        if (cmp_we_i) cmp_d = wdata_i;

        // Setting a match beats a simultaneous W1C clear.
        if (hit)                                   match_d = 1'b1;
        else if (status_we_i && wdata_i[MATCH_BIT]) match_d = 1'b0;

        if (status_we_i) en_d = wdata_i[EN_BIT];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= '0;
            cmp_q   <= '0;
            match_q <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
            en_q    <= en_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign cmp_o   = cmp_q;
    assign match_o = match_q;
    assign en_o    = en_q;
    assign irq_o   = match_q;

endmodule

// File: rtl/data_bus_mmio.sv
// data_bus_mmio: data RAM plus memory-mapped GPIO and timer for a
// single-cycle RV32 core. Reads are combinational, writes at clk_i edge.
// Ports:
//   clk_i, rst_i   clock, async active-low reset
//   we_i           write strobe
//   addr_i         byte address (bits [1:0] ignored)
//   wdata_i        write data
//   rdata_o        combinational read data
//   gpio_i         asynchronous GPIO inputs (2-flop synchronized)
//   gpio_o         registered GPIO outputs
//   irq_o          timer match flag
module data_bus_mmio
    import mmio_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAM_WORDS = 256,
    parameter int GPIO_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [WIDTH-1:0]  addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic              irq_o
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [WIDTH-1:0]  mem [RAM_WORDS];
    logic [3:0]        region;
    logic [5:0]        off;
    logic [AW-1:0]     ram_idx;
    logic              is_ram, is_per;
    logic [GPIO_W-1:0] gpio_out_q;
    logic [GPIO_W-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0]  cnt, cmp;
    logic              match, en;
    logic              unused_addr;

    assign region  = addr_i[WIDTH-1:WIDTH-4];
    assign off     = word_off(addr_i);
    assign ram_idx = addr_i[AW+1:2];   // upper in-region bits alias
    assign is_ram  = (region == REGION_RAM);
    assign is_per  = (region == REGION_PERIPH);

    // Address bits outside the decoded fields are don't-care.
    assign unused_addr = ^addr_i;

    // Data RAM: no reset, contents undefined until written.
    always_ff @(posedge clk_i) begin
        if (we_i && is_ram) mem[ram_idx] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            if (we_i && is_per && off == GPIO_OUT) gpio_out_q <= wdata_i[GPIO_W-1:0];
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
        end
    end

    assign gpio_o = gpio_out_q;

    mmio_timer #(.W(WIDTH)) u_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cnt_we_i    (we_i && is_per && off == TIMER_CNT),
        .cmp_we_i    (we_i && is_per && off == TIMER_CMP),
        .status_we_i (we_i && is_per && off == STATUS),
        .wdata_i     (wdata_i),
        .cnt_o       (cnt),
        .cmp_o       (cmp),
        .match_o     (match),
        .en_o        (en),
        .irq_o       (irq_o)
    );

    always_comb begin
        rdata_o = '0;
        if (is_ram) begin
            rdata_o = mem[ram_idx];
        end else if (is_per) begin
            case (off)
                GPIO_OUT:  rdata_o[GPIO_W-1:0] = gpio_out_q;
                GPIO_IN:   rdata_o[GPIO_W-1:0] = sync2_q;
                TIMER_CNT: rdata_o = cnt;
                TIMER_CMP: rdata_o = cmp;
                STATUS: begin
                    rdata_o[MATCH_BIT] = match;
                    rdata_o[EN_BIT]    = en;
                end
                default:   rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_mmio.sv
// Directed bench for data_bus_mmio: reset, RAM aliasing, GPIO, timer and
// simultaneous-event cases, all with hand-computed expectations.
module tb_data_bus_mmio;

    localparam logic [31:0] A_GOUT = 32'h1000_0000;
    localparam logic [31:0] A_GIN  = 32'h1000_0004;
    localparam logic [31:0] A_CNT  = 32'h1000_0008;
    localparam logic [31:0] A_CMP  = 32'h1000_000C;
    localparam logic [31:0] A_STAT = 32'h1000_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  gpio_in = 8'hA5;
    logic [7:0]  gpio_out;
    logic        irq;

    int checks = 0;
    int errors = 0;

    data_bus_mmio #(.WIDTH(32), .RAM_WORDS(256), .GPIO_W(8)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .gpio_i  (gpio_in),
        .gpio_o  (gpio_out),
        .irq_o   (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Combinational read within the current cycle.
    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        we   = 1'b0;
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    // Write committed at the next rising edge; returns 1 time unit after it.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit got_irq;

        // Reset
        #12;
        chk("rst_gpio_o", {24'h0, gpio_out}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk_rd("rst_cnt", A_CNT, 32'h0);
        chk_rd("rst_cmp", A_CMP, 32'h0);
        chk_rd("rst_stat", A_STAT, 32'h0);
        @(negedge clk); rst = 1'b1;
        chk_rd("gin_0edge", A_GIN, 32'h0);
        step();
        chk_rd("gin_1edge", A_GIN, 32'h0);
        step();
        chk_rd("gin_2edge", A_GIN, 32'h0000_00A5);

        // RAM and aliasing
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        chk_rd("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
        chk_rd("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
        chk_rd("ram_410", 32'h0000_0410, 32'hDEAD_BEEF);
        wr(32'h0000_0014, 32'h1122_3344);
        chk_rd("ram_14", 32'h0000_0014, 32'h1122_3344);
        chk_rd("ram_10_keep", 32'h0000_0010, 32'hDEAD_BEEF);
        chk_rd("unmap_rd", 32'h2000_0000, 32'h0);
        wr(32'h2000_0000, 32'h1234_5678);
        chk_rd("unmap_wr_rd", 32'h2000_0000, 32'h0);
        chk_rd("unmap_wr_ram", 32'h0000_0010, 32'hDEAD_BEEF);
        chk_rd("unmap_off", 32'h1000_0014, 32'h0);

        // GPIO
        wr(A_GOUT, 32'hFFFF_FF3C);
        chk("gout_pin", {24'h0, gpio_out}, 32'h0000_003C);
        chk_rd("gout_rd", A_GOUT, 32'h0000_003C);
        wr(A_GIN, 32'h0000_0000);
        chk_rd("gin_ro", A_GIN, 32'h0000_00A5);
        gpio_in = 8'h5A;
        step();
        chk_rd("gin_chg1", A_GIN, 32'h0000_00A5);
        step();
        chk_rd("gin_chg2", A_GIN, 32'h0000_005A);

        // Timer basic count and match
        wr(A_CMP, 32'd3);
        wr(A_STAT, 32'h2);
        for (int i = 0; i < 4; i++) begin
            chk_rd($sformatf("cnt_%0d", i), A_CNT, i);
            chk("irq_lo", {31'h0, irq}, 32'h0);
            step();
        end
        chk_rd("cnt_match", A_CNT, 32'h0);
        chk("irq_hi", {31'h0, irq}, 32'h1);
        chk_rd("stat_match", A_STAT, 32'h3);
        wr(A_STAT, 32'h3);
        chk_rd("w1c_stat", A_STAT, 32'h2);
        chk("w1c_irq", {31'h0, irq}, 32'h0);
        chk_rd("w1c_cnt", A_CNT, 32'h1);

        // W1C in the match cycle: set wins
        wr(A_CNT, 32'd3);
        chk_rd("ld_cnt3", A_CNT, 32'd3);
        wr(A_STAT, 32'h3);
        chk_rd("w1c_race_stat", A_STAT, 32'h3);
        chk("w1c_race_irq", {31'h0, irq}, 32'h1);
        chk_rd("w1c_race_cnt", A_CNT, 32'h0);

        // CNT write in the match cycle: write wins on CNT, MATCH still set
        wr(A_STAT, 32'h3);
        chk_rd("clr_stat", A_STAT, 32'h2);
        wr(A_CNT, 32'd3);
        wr(A_CNT, 32'h100);
        chk_rd("cntwr_race_cnt", A_CNT, 32'h100);
        chk_rd("cntwr_race_stat", A_STAT, 32'h3);

        // Wrap without match
        wr(A_STAT, 32'h3);
        wr(A_CMP, 32'd5);
        wr(A_CNT, 32'hFFFF_FFFF);
        chk_rd("wrap_pre", A_CNT, 32'hFFFF_FFFF);
        step();
        chk_rd("wrap_cnt", A_CNT, 32'h0);
        chk("wrap_irq", {31'h0, irq}, 32'h0);

        // Async reset mid-count with irq high
        wr(A_CMP, 32'd2);
        got_irq = 1'b0;
        for (int i = 0; i < 10 && !got_irq; i++) begin
            step();
            got_irq = irq;
        end
        chk("irq_before_rst", {31'h0, got_irq}, 32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_irq", {31'h0, irq}, 32'h0);
        chk_rd("arst_cnt", A_CNT, 32'h0);
        chk_rd("arst_stat", A_STAT, 32'h0);
        chk("arst_gpio", {24'h0, gpio_out}, 32'h0);
        @(negedge clk); rst = 1'b1;
        step(); step(); step();
        chk_rd("post_rst_cnt", A_CNT, 32'h0);
        chk_rd("post_rst_stat", A_STAT, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
